mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Round-robin select sequencer that sits directly upstream of the 3:1 `multiplexer` and drives its 2-bit select `f`. Three sources (a, b, c) raise requests; the block grants one at a time, holds each grant for a bounded tenure so the mux output stays stable, and encodes the winner as `f`. Its outputs are fully registered, so the downstream mux sees glitch-free select changes only on clock edges.

## Interface
- `HOLD`, default 4: maximum tenure in clock cycles of one grant while another source is waiting; legal range 1..255.
- `CW`, default 8: tenure counter width; must satisfy HOLD-1 < 2**CW.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `en`  input  1  advance enable; when 0 all state and outputs hold.
- `req`  input  3  request per source: bit0 = a, bit1 = b, bit2 = c.
- `f`  output  2  mux select: 2'b00 = a, 2'b01 = b, 2'b10 = c; 2'b11 is never driven.
- `grant`  output  3  one-hot current grant, or 3'b000 when idle.
- `busy`  output  1  1 while a grant is active (`grant` != 0).
- `switch_pulse`  output  1  one-cycle strobe on the edge where `grant` takes a new non-zero value.

## Operation
- The reset values are `f`=2'b00, `grant`=3'b000, `busy`=0, and `switch_pulse`=0. Reset also sets the internal `state` to IDLE, the tenure counter to 0 and the last-granted pointer to c, so the first search order is a, b, c.
- `rst` dominates `en`. A reset that arrives mid-grant drops the grant on the next edge with no pulse.
- Rotation: the search starts at the index after the last granted one and wraps as a→b→c→a. The first asserted `req` found in that order wins.
- State IDLE is entered when no requests are sampled:
  - it stays in IDLE while `req`==0;
  - on any `req`!=0 it arbitrates, moves to GRANT, loads the counter with HOLD-1 and asserts `switch_pulse`.
- State GRANT:
  - Each enabled edge: if `req[cur]`==0, the tenure ends at this edge.
  - Otherwise, if the counter is 0, the tenure ends at this edge.
  - Otherwise the counter decrements by 1.
- End of tenure in GRANT:
  - The block arbitrates among requests sampled at this edge, with the current index searched last.
  - If the winner differs from the current index, it loads the new grant, reloads the counter with HOLD-1 and pulses `switch_pulse`.
  - If the winner is the current index (only self still requesting), it keeps the grant and reloads the counter with no pulse.
  - If there is no winner, it goes to IDLE and drives `grant`=0; `f` keeps its last value.
- `f` always equals the binary encoding of the current or most recent grant. `f` and `grant` update on the same edge.
- `en`=0: the counter, `state`, pointer and outputs all freeze. `switch_pulse` is forced to 0 while `en`=0.

## Timing
- Request-to-grant latency from IDLE is 1 edge: `req` is sampled at edge N and `grant`/`f` are valid after edge N.
- Release latency is 1 edge: `req[cur]` is sampled low at edge N, and after edge N the grant moves to the next source or goes idle.
- With contention, each grant lasts exactly HOLD cycles.
- HOLD=1 gives a grant rotation every cycle under full load.
- `switch_pulse` is high for exactly the one cycle following the edge that changed `grant`.
- No combinational path exists from `req`/`en` to any output.

## Test plan
- Reset mid-grant: run with `req`=3'b111, assert `rst` for one edge → after that edge `grant`=000, `f`=00, `busy`=0, `switch_pulse`=0. Release reset and hold `req`=3'b111 → the next grant is a.
- Single request: HOLD=4, `req`=3'b010 held for 10 cycles → `grant`=010 and `f`=01 one edge later. The grant stays continuous with exactly one `switch_pulse`, and the counter reloads every 4 cycles.
- Full contention: HOLD=4, `req`=3'b111 → `f` sequence 00×4, 01×4, 10×4, 00×4. `switch_pulse` fires at each change and `f` never shows 11.
- Early release: a is granted, then `req[0]` drops after 2 cycles while `req`=3'b100 → `grant`=100 and `f`=10 on the edge sampling the drop. When all requests drop, `grant`=000 and `f` stays 10.
- Enable freeze: during a b grant with counter=2, hold `en`=0 for 5 cycles with `req`=3'b101 → outputs are unchanged and `switch_pulse`=0. After `en`=1, b is held for 2 more edges, then c is granted.
- Wrap and skip: last grant c, `req`=3'b110 → the next grant is b (a skipped, the search wrapped past c). Then `req`=3'b101 → the grant goes to c only after b releases.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin select sequencer for a 3:1 mux.
// Grants one of a/b/c with bounded tenure; all outputs registered.
module mux_sel_arbiter #(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] req,
  output logic [1:0] f,
  output logic [2:0] grant,
  output logic       busy,
  output logic       switch_pulse
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ptr;
  logic [1:0]    r_f;
  logic [2:0]    r_grant;
  logic          r_busy;
  logic          r_pulse;

  state_t        w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [1:0]    w_ptr_n;
  logic [1:0]    w_f_n;
  logic [2:0]    w_grant_n;
  logic          w_busy_n;
  logic          w_pulse_n;

  logic          w_hit;
  logic [1:0]    w_win;
  logic          w_end;
  logic [1:0]    w_i0;
  logic [1:0]    w_i1;

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] x);
    return 3'b001 << x;
  endfunction

  // Search order: the index after the last grant, wrapping; last grant last.
  always_comb begin
    w_i0  = nxt(r_ptr);
    w_i1  = nxt(w_i0);
    w_hit = 1'b1;
    w_win = r_ptr;
    if (req[w_i0])
      w_win = w_i0;
    else if (req[w_i1])
      w_win = w_i1;
    else if (req[r_ptr])
      w_win = r_ptr;
    else
      w_hit = 1'b0;
  end

  // Next-state and registered-output computation.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ptr_n   = r_ptr;
    w_f_n     = r_f;
    w_grant_n = r_grant;
    w_busy_n  = r_busy;
    w_pulse_n = 1'b0;
    w_end     = (r_state == S_GRANT) &&
                (!req[r_ptr] || (r_cnt == '0));
    if (en) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            w_state_n = S_GRANT;
            w_cnt_n   = RELOAD;
            w_ptr_n   = w_win;
            w_f_n     = w_win;
            w_grant_n = onehot(w_win);
            w_busy_n  = 1'b1;
            w_pulse_n = 1'b1;
          end
        end
        S_GRANT: begin
          if (!w_end) begin
            w_cnt_n = r_cnt - 1'b1;
          end else if (!w_hit) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_grant_n = 3'b000;
            w_busy_n  = 1'b0;
          end else if (w_win != r_ptr) begin
            w_cnt_n   = RELOAD;
            w_ptr_n   = w_win;
            w_f_n     = w_win;
            w_grant_n = onehot(w_win);
            w_pulse_n = 1'b1;
          end else begin
            w_cnt_n = RELOAD;
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 2'd2;
      r_f     <= 2'b00;
      r_grant <= 3'b000;
      r_busy  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
      r_f     <= w_f_n;
      r_grant <= w_grant_n;
      r_busy  <= w_busy_n;
      r_pulse <= w_pulse_n;
    end
  end

  assign f            = r_f;
  assign grant        = r_grant;
  assign busy         = r_busy;
  assign switch_pulse = r_pulse;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed checks of the round-robin select
// sequencer with HOLD=4.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] req;
  logic [1:0] f;
  logic [2:0] grant;
  logic       busy;
  logic       switch_pulse;

  int tests;
  int failed;
  int pulses;

  mux_sel_arbiter #(
    .HOLD(4),
    .CW  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .f           (f),
    .grant       (grant),
    .busy        (busy),
    .switch_pulse(switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [2:0] g,
                         input logic [1:0] ff,
                         input logic b,
                         input logic p);
    chk({tag, ".grant"}, {5'd0, grant}, {5'd0, g});
    chk({tag, ".f"}, {6'd0, f}, {6'd0, ff});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, ".pulse"}, {7'd0, switch_pulse}, {7'd0, p});
  endtask

  initial begin
    logic [1:0] ef;
    tests  = 0;
    failed = 0;
    rst = 1'b1;
    en  = 1'b1;
    req = 3'b000;
    step();
    step();
    chk_all("reset", 3'b000, 2'b00, 1'b0, 1'b0);

    // reset mid-grant
    rst = 1'b0;
    req = 3'b111;
    step();
    chk_all("first_a", 3'b001, 2'b00, 1'b1, 1'b1);
    step();
    chk_all("hold_a", 3'b001, 2'b00, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_all("mid_rst", 3'b000, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_all("post_rst_a", 3'b001, 2'b00, 1'b1, 1'b1);

    // full contention: a x4, b x4, c x4, a x4
    for (int k = 1; k < 16; k++) begin
      step();
      ef = 2'((k / 4) % 3);
      chk($sformatf("rr%0d.f", k), {6'd0, f}, {6'd0, ef});
      chk($sformatf("rr%0d.g", k), {5'd0, grant},
          {5'd0, 3'b001 << ef});
      chk($sformatf("rr%0d.p", k), {7'd0, switch_pulse},
          {7'd0, (k % 4) == 0});
      chk($sformatf("rr%0d.f11", k), {7'd0, f == 2'b11}, 8'd0);
    end

    // single request held
    rst = 1'b1;
    req = 3'b000;
    step();
    rst = 1'b0;
    req = 3'b010;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (switch_pulse) pulses++;
      chk($sformatf("single%0d.g", k), {5'd0, grant}, 8'h02);
      chk($sformatf("single%0d.f", k), {6'd0, f}, 8'h01);
    end
    chk("single.pulses", 8'(pulses), 8'd1);

    // early release
    rst = 1'b1;
    req = 3'b000;
    step();
    rst = 1'b0;
    req = 3'b001;
    step();
    chk_all("early_a", 3'b001, 2'b00, 1'b1, 1'b1);
    step();
    step();
    req = 3'b100;
    step();
    chk_all("early_c", 3'b100, 2'b10, 1'b1, 1'b1);
    req = 3'b000;
    step();
    chk_all("early_idle", 3'b000, 2'b10, 1'b0, 1'b0);

    // enable freeze during b grant with counter=2
    req = 3'b010;
    step();
    chk_all("frz_b", 3'b010, 2'b01, 1'b1, 1'b1);
    step();
    en  = 1'b0;
    req = 3'b101;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all($sformatf("frz%0d", k), 3'b010, 2'b01, 1'b1, 1'b0);
    end
    en  = 1'b1;
    req = 3'b111;
    step();
    chk_all("thaw1", 3'b010, 2'b01, 1'b1, 1'b0);
    step();
    chk_all("thaw2", 3'b010, 2'b01, 1'b1, 1'b0);
    step();
    chk_all("thaw_c", 3'b100, 2'b10, 1'b1, 1'b1);

    // wrap and skip: last grant c
    req = 3'b000;
    step();
    chk_all("wrap_idle", 3'b000, 2'b10, 1'b0, 1'b0);
    req = 3'b110;
    step();
    chk_all("wrap_b", 3'b010, 2'b01, 1'b1, 1'b1);
    req = 3'b111;
    step();
    chk_all("wrap_hold_b", 3'b010, 2'b01, 1'b1, 1'b0);
    req = 3'b101;
    step();
    chk_all("wrap_c", 3'b100, 2'b10, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
